div_iter_unit: RTL and testbench

Iterative 32-bit radix-2 divider that serves as the responder on the divider stream interface driven by the execute stage. It replaces the vendor divider core for `div`/`divu`. It accepts a dividend and a divisor on two independent valid/ready input channels and computes quotient and remainder over 32 iteration cycles. It returns `{quotient, remainder}` on a single-cycle output pulse with no output backpressure. One instance with `SIGNED=1` serves `div` and one with `SIGNED=0` serves `divu`.

---
 rtl/div_iter_unit_pkg.sv | 25 ++
 rtl/div_iter_unit_step.sv | 28 ++
 rtl/div_iter_unit.sv | 172 +++++++++++++++++
 tb/tb_div_iter_unit.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/div_iter_unit_pkg.sv
// div_iter_unit_pkg: shared definitions for the iterative radix-2 divider.
//   - FSM state encoding (DIV_IDLE / DIV_BUSY / DIV_DONE)
//   - iteration count and end-to-end latency
//   - field positions inside the 64-bit result word (quotient high, remainder low)
//   - mag32: two's-complement magnitude helper
package div_iter_unit_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  localparam int DIV_ITERS    = 32;
  localparam int DIV_LATENCY  = 33;
  localparam int DOUT_QUO_LSB = 32;
  localparam int DOUT_REM_LSB = 0;

  // Magnitude of x when sgn is set and x is negative; 0x80000000 maps to itself,
  // which is the correct unsigned magnitude.
  function automatic logic [31:0] mag32(input logic [31:0] x, input logic sgn);
    return (sgn && x[31]) ? (~x + 32'd1) : x;
  endfunction

endpackage

// File: rtl/div_iter_unit_step.sv
// div_iter_step: one combinational restoring-division step.
// Ports:
//   rem      in  33  partial remainder
//   quo      in  32  dividend/quotient shift register
//   dmag     in  32  divisor magnitude
//   rem_next out 33  partial remainder after the step
//   quo_next out 32  shift register after the step (new quotient bit in LSB)
module div_iter_step (
  input  logic [32:0] rem,
  input  logic [31:0] quo,
  input  logic [31:0] dmag,
  output logic [32:0] rem_next,
  output logic [31:0] quo_next
);

  logic [33:0] wide;
  logic [33:0] diff;
  logic        ge;

  always_comb begin
    wide     = {rem, quo[31]};
    diff     = wide - {2'b00, dmag};
    ge       = (wide >= {2'b00, dmag});
    rem_next = 33'(ge ? diff : wide);
    quo_next = {quo[30:0], ge};
  end

endmodule

// File: rtl/div_iter_unit.sv
// div_iter_unit: iterative 32-bit radix-2 restoring divider with two independent
// valid/ready operand channels and a single-cycle result pulse (no backpressure).
// Result: m_axis_dout_tdata = {quotient, remainder}; tuser flags divide-by-zero.
// Latency 33 cycles from the second operand handshake, one division per 34 cycles.
//
// Parameter:
//   SIGNED   1: two's-complement division, 0: unsigned division
// Build option:
//   DIV_ZERO_FASTPATH_EN  when defined, a zero divisor skips the iterations and
//                         the result pulse appears one cycle after the start edge.
// Ports:
//   clk, reset (sync, active high)
//   s_axis_dividend_{tvalid,tready,tdata}  dividend channel
//   s_axis_divisor_{tvalid,tready,tdata}   divisor channel
//   m_axis_dout_{tvalid,tdata,tuser}       result pulse, {quo,rem}, div-by-zero
//
// state    | meaning
// DIV_IDLE | collecting operands, tready = !captured per channel
// DIV_BUSY | 32 restoring steps, counter 31 down to 0
// DIV_DONE | result pulse, captured flags cleared on exit
module div_iter_unit
  import div_iter_unit_pkg::*;
#(
  parameter bit SIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s_axis_dividend_tvalid,
  output logic        s_axis_dividend_tready,
  input  logic [31:0] s_axis_dividend_tdata,
  input  logic        s_axis_divisor_tvalid,
  output logic        s_axis_divisor_tready,
  input  logic [31:0] s_axis_divisor_tdata,
  output logic        m_axis_dout_tvalid,
  output logic [63:0] m_axis_dout_tdata,
  output logic        m_axis_dout_tuser
);

  div_state_e  state, state_nxt;

  logic        dvd_cap, dvs_cap;
  logic [31:0] dvd_reg, dvs_reg;
  logic        dvd_fire, dvs_fire;
  logic [31:0] dvd_cur, dvs_cur;
  logic        start, zero_start;

  logic [32:0] rem_q, rem_nx;
  logic [31:0] quo_q, quo_nx, dmag_q;
  logic [4:0]  cnt_q;
  logic        q_neg, r_neg, dvs_zero;

  logic [31:0] fin_quo, fin_rem;
  logic [63:0] dout_q;
  logic        user_q;

  div_iter_step u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .dmag     (dmag_q),
    .rem_next (rem_nx),
    .quo_next (quo_nx)
  );

  always_comb begin
    s_axis_dividend_tready = (state == DIV_IDLE) && !dvd_cap;
    s_axis_divisor_tready  = (state == DIV_IDLE) && !dvs_cap;
    dvd_fire = s_axis_dividend_tvalid && s_axis_dividend_tready;
    dvs_fire = s_axis_divisor_tvalid  && s_axis_divisor_tready;
    // Operand as seen on the start edge: held copy or the one arriving now.
    dvd_cur  = dvd_cap ? dvd_reg : s_axis_dividend_tdata;
    dvs_cur  = dvs_cap ? dvs_reg : s_axis_divisor_tdata;
    start    = (state == DIV_IDLE) && (dvd_cap || dvd_fire) && (dvs_cap || dvs_fire);
`ifdef DIV_ZERO_FASTPATH_EN
    zero_start = start && (dvs_cur == 32'd0);
`else
    zero_start = 1'b0;
`endif
    fin_quo  = q_neg ? (~quo_nx + 32'd1) : quo_nx;
    fin_rem  = 32'(r_neg ? (~rem_nx + 33'd1) : rem_nx);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      DIV_IDLE: begin
        if (zero_start)  state_nxt = DIV_DONE;
        else if (start)  state_nxt = DIV_BUSY;
      end
      DIV_BUSY: begin
        if (cnt_q == 5'd0) state_nxt = DIV_DONE;
      end
      DIV_DONE: state_nxt = DIV_IDLE;
      default:  state_nxt = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= DIV_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dvd_cap  <= 1'b0;
      dvs_cap  <= 1'b0;
      dvd_reg  <= '0;
      dvs_reg  <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dmag_q   <= '0;
      cnt_q    <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      dvs_zero <= 1'b0;
      dout_q   <= '0;
      user_q   <= 1'b0;
    end else begin
      if (dvd_fire) begin
        dvd_reg <= s_axis_dividend_tdata;
        dvd_cap <= 1'b1;
      end
      if (dvs_fire) begin
        dvs_reg <= s_axis_divisor_tdata;
        dvs_cap <= 1'b1;
      end
      if (state == DIV_DONE) begin
        dvd_cap <= 1'b0;
        dvs_cap <= 1'b0;
      end

      if (start) begin
        rem_q    <= '0;
        quo_q    <= mag32(dvd_cur, SIGNED);
        dmag_q   <= mag32(dvs_cur, SIGNED);
        q_neg    <= SIGNED && (dvd_cur[31] ^ dvs_cur[31]);
        r_neg    <= SIGNED && dvd_cur[31];
        dvs_zero <= (dvs_cur == 32'd0);
        cnt_q    <= 5'(DIV_ITERS - 1);
      end

      if (zero_start) begin
        dout_q[DOUT_QUO_LSB +: 32] <= 32'hFFFF_FFFF;
        dout_q[DOUT_REM_LSB +: 32] <= dvd_cur;
        user_q                     <= 1'b1;
      end

      if (state == DIV_BUSY) begin
        rem_q <= rem_nx;
        quo_q <= quo_nx;
        cnt_q <= cnt_q - 5'd1;
        if (cnt_q == 5'd0) begin
          // A zero divisor iterates to all-ones anyway, but the remainder must be
          // the raw (signed) dividend, so the result is forced here.
          if (dvs_zero) begin
            dout_q[DOUT_QUO_LSB +: 32] <= 32'hFFFF_FFFF;
            dout_q[DOUT_REM_LSB +: 32] <= dvd_reg;
            user_q                     <= 1'b1;
          end else begin
            dout_q[DOUT_QUO_LSB +: 32] <= fin_quo;
            dout_q[DOUT_REM_LSB +: 32] <= fin_rem;
            user_q                     <= 1'b0;
          end
        end
      end
    end
  end

  assign m_axis_dout_tvalid = (state == DIV_DONE);
  assign m_axis_dout_tdata  = dout_q;
  assign m_axis_dout_tuser  = user_q;

endmodule

// File: tb/tb_div_iter_unit.sv
module tb_div_iter_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        dvd_valid, dvs_valid;
  logic [31:0] dvd_data, dvs_data;

  logic        dvd_rdy_s, dvs_rdy_s, out_valid_s, out_user_s;
  logic [63:0] out_data_s;
  logic        dvd_rdy_u, dvs_rdy_u, out_valid_u, out_user_u;
  logic [63:0] out_data_u;

  div_iter_unit #(.SIGNED(1'b1)) dut_s (
    .clk                    (clk),
    .reset                  (reset),
    .s_axis_dividend_tvalid (dvd_valid),
    .s_axis_dividend_tready (dvd_rdy_s),
    .s_axis_dividend_tdata  (dvd_data),
    .s_axis_divisor_tvalid  (dvs_valid),
    .s_axis_divisor_tready  (dvs_rdy_s),
    .s_axis_divisor_tdata   (dvs_data),
    .m_axis_dout_tvalid     (out_valid_s),
    .m_axis_dout_tdata      (out_data_s),
    .m_axis_dout_tuser      (out_user_s)
  );

  div_iter_unit #(.SIGNED(1'b0)) dut_u (
    .clk                    (clk),
    .reset                  (reset),
    .s_axis_dividend_tvalid (dvd_valid),
    .s_axis_dividend_tready (dvd_rdy_u),
    .s_axis_dividend_tdata  (dvd_data),
    .s_axis_divisor_tvalid  (dvs_valid),
    .s_axis_divisor_tready  (dvs_rdy_u),
    .s_axis_divisor_tdata   (dvs_data),
    .m_axis_dout_tvalid     (out_valid_u),
    .m_axis_dout_tdata      (out_data_u),
    .m_axis_dout_tuser      (out_user_u)
  );

  always #5 clk = ~clk;

`ifdef DIV_ZERO_FASTPATH_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 33;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    int          ga;
    int          gb;
    logic [64:0] es;  // {tuser, quotient, remainder} for SIGNED=1
    logic [64:0] eu;  // same for SIGNED=0
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // Reference: plain integer division on 64-bit values.
  function automatic logic [64:0] model(input logic [31:0] a, input logic [31:0] b, input bit sgn);
    longint sa, sb, q, r;
    if (b == 32'd0) return {1'b1, 32'hFFFF_FFFF, a};
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'(a);
      sb = longint'(b);
    end
    q = sa / sb;
    r = sa % sb;
    return {1'b0, q[31:0], r[31:0]};
  endfunction

  task automatic run_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                        input int ga, input int gb,
                        input logic [64:0] es, input logic [64:0] eu);
    int t, lat, first_s, first_u, pulses_s, pulses_u;
    bit ha, hb, hold_bad, rdy_after;
    logic [63:0] ds, du;
    logic us, uu;
    lat = (b == 32'd0) ? ZLAT : 33;
    ha = 0; hb = 0; hold_bad = 0; t = 0;
    first_s = -1; first_u = -1; pulses_s = 0; pulses_u = 0;
    ds = '0; du = '0; us = 0; uu = 0; rdy_after = 0;
    while (!(ha && hb) && t < 100) begin
      @(negedge clk);
      dvd_valid = (t >= ga) && !ha;
      dvs_valid = (t >= gb) && !hb;
      dvd_data  = ha ? $urandom : a;
      dvs_data  = hb ? $urandom : b;
      if (ha && dvd_rdy_s) hold_bad = 1;
      if (hb && dvs_rdy_s) hold_bad = 1;
      if (dvd_valid && dvd_rdy_s) ha = 1;
      if (dvs_valid && dvs_rdy_s) hb = 1;
      t++;
    end
    chk({nm, ".handshake"}, 64'(ha && hb), 64'd1);
    if (!(ha && hb)) return;
    if (ga != gb) chk({nm, ".hold_ready_low"}, 64'(hold_bad), 64'd0);
    for (int n = 1; n <= lat + 1; n++) begin
      @(negedge clk);
      if (n == 1) begin
        dvd_valid = 0; dvs_valid = 0;
        dvd_data = $urandom; dvs_data = $urandom;
      end
      if (out_valid_s) begin
        pulses_s++;
        if (first_s < 0) begin first_s = n; ds = out_data_s; us = out_user_s; end
      end
      if (out_valid_u) begin
        pulses_u++;
        if (first_u < 0) begin first_u = n; du = out_data_u; uu = out_user_u; end
      end
      if (n == lat + 1) rdy_after = dvd_rdy_s && dvs_rdy_s && dvd_rdy_u && dvs_rdy_u;
    end
    chk({nm, ".lat_s"},    64'(first_s),  64'(lat));
    chk({nm, ".lat_u"},    64'(first_u),  64'(lat));
    chk({nm, ".pulses"},   64'(pulses_s + pulses_u), 64'd2);
    chk({nm, ".data_s"},   ds,            es[63:0]);
    chk({nm, ".user_s"},   64'(us),       64'(es[64]));
    chk({nm, ".data_u"},   du,            eu[63:0]);
    chk({nm, ".user_u"},   64'(uu),       64'(eu[64]));
    chk({nm, ".rdy_after"}, 64'(rdy_after), 64'd1);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b;
    int sel, hs, p1, p2, np;
    bit seen, rdy;
    logic [63:0] d1s, d2s, d1u, d2u;

    tbl[0] = '{32'd100,       32'd7,         0, 0, {1'b0, 32'h0000000E, 32'h00000002}, {1'b0, 32'h0000000E, 32'h00000002}};
    tbl[1] = '{32'hFFFFFFF9,  32'd2,         0, 0, {1'b0, 32'hFFFFFFFD, 32'hFFFFFFFF}, {1'b0, 32'h7FFFFFFC, 32'h00000001}};
    tbl[2] = '{32'h80000000,  32'hFFFFFFFF,  0, 0, {1'b0, 32'h80000000, 32'h00000000}, {1'b0, 32'h00000000, 32'h80000000}};
    tbl[3] = '{32'd5,         32'd0,         0, 0, {1'b1, 32'hFFFFFFFF, 32'h00000005}, {1'b1, 32'hFFFFFFFF, 32'h00000005}};
    tbl[4] = '{32'd50,        32'd5,         0, 6, {1'b0, 32'h0000000A, 32'h00000000}, {1'b0, 32'h0000000A, 32'h00000000}};
    tbl[5] = '{32'hFFFFFF9C,  32'd0,         3, 0, {1'b1, 32'hFFFFFFFF, 32'hFFFFFF9C}, {1'b1, 32'hFFFFFFFF, 32'hFFFFFF9C}};
    tbl[6] = '{32'd7,         32'hFFFFFFFE,  0, 0, {1'b0, 32'hFFFFFFFD, 32'h00000001}, {1'b0, 32'h00000000, 32'h00000007}};
    tbl[7] = '{32'hFFFFFFFF,  32'd1,         0, 0, {1'b0, 32'hFFFFFFFF, 32'h00000000}, {1'b0, 32'hFFFFFFFF, 32'h00000000}};

    reset = 1; dvd_valid = 0; dvs_valid = 0; dvd_data = '0; dvs_data = '0;
    repeat (3) @(negedge clk);
    reset = 0;
    @(negedge clk);
    chk("reset.tready", 64'({dvd_rdy_s, dvs_rdy_s, dvd_rdy_u, dvs_rdy_u}), 64'hF);
    chk("reset.tvalid", 64'({out_valid_s, out_valid_u}), 64'd0);
    chk("reset.tdata_s", out_data_s, 64'd0);
    chk("reset.tdata_u", out_data_u, 64'd0);
    chk("reset.tuser", 64'({out_user_s, out_user_u}), 64'd0);

    for (int i = 0; i < 8; i++)
      run_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].ga, tbl[i].gb, tbl[i].es, tbl[i].eu);

    // Reset in the middle of an iteration run.
    @(negedge clk);
    dvd_valid = 1; dvs_valid = 1; dvd_data = 32'd1000; dvs_data = 32'd3;
    chk("rst.start_ready", 64'(dvd_rdy_s && dvs_rdy_s), 64'd1);
    seen = 0; rdy = 0;
    for (int n = 1; n <= 45; n++) begin
      @(negedge clk);
      if (n == 1)  begin dvd_valid = 0; dvs_valid = 0; end
      if (n == 12) reset = 1;
      if (n == 13) reset = 0;
      if (n == 14) begin
        rdy = dvd_rdy_s && dvs_rdy_s && dvd_rdy_u && dvs_rdy_u;
        chk("rst.tdata", out_data_s | out_data_u, 64'd0);
      end
      if (out_valid_s || out_valid_u) seen = 1;
    end
    chk("rst.no_pulse", 64'(seen), 64'd0);
    chk("rst.ready_after", 64'(rdy), 64'd1);
    run_op("after_rst", 32'd9, 32'd3, 0, 0, {1'b0, 32'd3, 32'd0}, {1'b0, 32'd3, 32'd0});

    // Back-to-back: second operand pair held valid through BUSY and DONE.
    @(negedge clk);
    dvd_valid = 1; dvs_valid = 1; dvd_data = 32'hFFFFCFC7; dvs_data = 32'd67;
    hs = -1; p1 = -1; p2 = -1; np = 0;
    d1s = '0; d2s = '0; d1u = '0; d2u = '0;
    for (int n = 1; n <= 72; n++) begin
      @(negedge clk);
      if (n == 1) begin dvd_data = 32'hDEADBEEF; dvs_data = 32'h00001234; end
      if (hs >= 0 && n == hs + 1) begin dvd_valid = 0; dvs_valid = 0; end
      if (hs < 0 && n > 1 && dvd_valid && dvd_rdy_s && dvs_rdy_s) hs = n;
      if (out_valid_s) begin
        np++;
        if (p1 < 0) begin p1 = n; d1s = out_data_s; d1u = out_data_u; end
        else if (p2 < 0) begin p2 = n; d2s = out_data_s; d2u = out_data_u; end
      end
    end
    chk("b2b.capture_cycle", 64'(hs), 64'd34);
    chk("b2b.first_pulse", 64'(p1), 64'd33);
    chk("b2b.spacing", 64'(p2 - p1), 64'd34);
    chk("b2b.pulse_count", 64'(np), 64'd2);
    chk("b2b.data1_s", d1s, model(32'hFFFFCFC7, 32'd67, 1'b1) & 65'h0_FFFF_FFFF_FFFF_FFFF);
    chk("b2b.data2_s", d2s, model(32'hDEADBEEF, 32'h1234, 1'b1) & 65'h0_FFFF_FFFF_FFFF_FFFF);
    chk("b2b.data1_u", d1u, model(32'hFFFFCFC7, 32'd67, 1'b0) & 65'h0_FFFF_FFFF_FFFF_FFFF);
    chk("b2b.data2_u", d2u, model(32'hDEADBEEF, 32'h1234, 1'b0) & 65'h0_FFFF_FFFF_FFFF_FFFF);

    // Randomized operands against the reference model.
    for (int i = 0; i < 30; i++) begin
      a = $urandom;
      sel = $urandom_range(0, 7);
      case (sel)
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'hFFFFFFFF;
        3:       begin b = $urandom; a = 32'($urandom_range(0, 1000)); end
        default: b = $urandom;
      endcase
      run_op($sformatf("rnd%0d", i), a, b, $urandom_range(0, 3), $urandom_range(0, 3),
             model(a, b, 1'b1), model(a, b, 1'b0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
